// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer.
package bp_pkg;

  // Tags and targets are held at a fixed maximum width. Only the low PC_W bits of a
  // target and the low PC_W-IDX_W-2 bits of a tag are ever non-zero, so synthesis
  // drops the unused flops.
  localparam int unsigned MaxPcW = 32;

  typedef enum logic [0:0] {
    BP_CLEAR = 1'b0,
    BP_RUN   = 1'b1
  } bp_state_e;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic              valid;
    logic [MaxPcW-1:0] tag;
    logic [1:0]        ctr;
    logic [MaxPcW-1:0] target;
  } bp_entry_t;

  // Tag is everything above the index and the 2-bit byte offset. It is zero when
  // the PC has no bits left above the index.
  function automatic logic [MaxPcW-1:0] bp_tag(input logic [MaxPcW-1:0] pc,
                                                input int unsigned       idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup, update and status signals between the fetch/execute stages and the BTB.
interface branch_predictor_if #(
  parameter int unsigned PC_W  = 13,
  parameter int unsigned LANES = 2
);
  logic                  hold;
  logic [LANES*PC_W-1:0] lk_pc;
  logic [LANES-1:0]      lk_hit;
  logic [LANES-1:0]      lk_taken;
  logic [LANES*PC_W-1:0] lk_target;
  logic                  upd_valid;
  logic [PC_W-1:0]       upd_pc;
  logic                  upd_taken;
  logic [PC_W-1:0]       upd_target;
  logic                  ready;

  modport master (
    output hold, lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  lk_hit, lk_taken, lk_target, ready
  );

  modport slave (
    input  hold, lk_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output lk_hit, lk_taken, lk_target, ready
  );
endinterface

// File: rtl/bp_ctr2.sv
// 2-bit saturating direction counter: next value from current value and outcome.
module bp_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  // Step toward the outcome, saturating at both ends.
  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      CTR_SNT: ctr_o = taken_i ? CTR_WNT : CTR_SNT;
      CTR_WNT: ctr_o = taken_i ? CTR_WT  : CTR_SNT;
      CTR_WT:  ctr_o = taken_i ? CTR_ST  : CTR_WNT;
      CTR_ST:  ctr_o = taken_i ? CTR_ST  : CTR_WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, LANES lookup ports, one update
// port, a post-reset clear sweep and same-cycle update-to-lookup bypass.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned ENTRIES = 256,
  parameter int unsigned LANES   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bp_io
);

  localparam int unsigned    IDX_W    = $clog2(ENTRIES);
  localparam logic [IDX_W:0] ClrLast  = (IDX_W+1)'(ENTRIES - 1);
  localparam logic [IDX_W:0] ClrStep  = (IDX_W+1)'(1);

  bp_state_e       state_q;
  logic [IDX_W:0]  clr_idx_q;
  logic            ready_q;
  bp_entry_t       tbl_q [ENTRIES];

  // Update side
  logic [MaxPcW-1:0] upd_pc_ext;
  logic [MaxPcW-1:0] upd_tgt_ext;
  logic [MaxPcW-1:0] upd_tag;
  logic [IDX_W-1:0]  upd_idx;
  bp_entry_t         upd_old;
  logic              upd_hit;
  logic [1:0]        upd_ctr_nxt;
  logic              upd_we;
  bp_entry_t         upd_ent;

  // Shared write port
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  bp_entry_t         wr_ent;

  // Lookup side
  logic [MaxPcW-1:0]     lk_pc_ext [LANES];
  logic [MaxPcW-1:0]     lk_tag    [LANES];
  logic [IDX_W-1:0]      lk_idx    [LANES];
  bp_entry_t             lk_ent    [LANES];
  logic [LANES-1:0]      lk_hit_d,    lk_hit_q;
  logic [LANES-1:0]      lk_taken_d,  lk_taken_q;
  logic [LANES*PC_W-1:0] lk_target_d, lk_target_q;

  // Split the resolved PC into index and tag.
  always_comb begin
    upd_pc_ext  = MaxPcW'(bp_io.upd_pc);
    upd_tgt_ext = MaxPcW'(bp_io.upd_target);
    upd_tag     = bp_tag(upd_pc_ext, IDX_W);
    upd_idx     = IDX_W'(upd_pc_ext >> 2);
  end

  assign upd_old = tbl_q[upd_idx];
  assign upd_hit = upd_old.valid && (upd_old.tag == upd_tag);

  bp_ctr2 u_ctr (
    .ctr_i   (upd_old.ctr),
    .taken_i (bp_io.upd_taken),
    .ctr_o   (upd_ctr_nxt)
  );

  // Post-update entry; updates only land in RUN and are dropped under reset.
  always_comb begin
    upd_we  = 1'b0;
    upd_ent = upd_old;
    if (state_q == BP_RUN && !rst_i && bp_io.upd_valid) begin
      if (upd_hit) begin
        upd_we      = 1'b1;
        upd_ent.ctr = upd_ctr_nxt;
        if (bp_io.upd_taken) begin
          upd_ent.target = upd_tgt_ext;
        end
      end else if (bp_io.upd_taken) begin
        upd_we         = 1'b1;
        upd_ent.valid  = 1'b1;
        upd_ent.tag    = upd_tag;
        upd_ent.ctr    = CTR_WT;
        upd_ent.target = upd_tgt_ext;
      end
    end
  end

  // Single write port: the clear sweep owns it in CLEAR, updates own it in RUN.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = upd_idx;
    wr_ent = upd_ent;
    if (!rst_i) begin
      if (state_q == BP_CLEAR) begin
        wr_en  = 1'b1;
        wr_idx = clr_idx_q[IDX_W-1:0];
        wr_ent = '0;
      end else if (upd_we) begin
        wr_en = 1'b1;
      end
    end
  end

  // Table storage; contents are invalidated by the sweep, so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tbl_q[wr_idx] <= wr_ent;
    end
  end

  // CLEAR/RUN sequencer with registered ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= BP_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        BP_CLEAR: begin
          clr_idx_q <= clr_idx_q + ClrStep;
          if (clr_idx_q == ClrLast) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end
        end
        BP_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= BP_CLEAR;
        end
      endcase
    end
  end

  // Per-lane read with bypass of this cycle's update; all lanes miss while clearing.
  always_comb begin
    lk_hit_d    = '0;
    lk_taken_d  = '0;
    lk_target_d = '0;
    for (int i = 0; i < LANES; i++) begin
      lk_pc_ext[i] = MaxPcW'(bp_io.lk_pc[i*PC_W +: PC_W]);
      lk_idx[i]    = IDX_W'(lk_pc_ext[i] >> 2);
      lk_tag[i]    = bp_tag(lk_pc_ext[i], IDX_W);
      lk_ent[i]    = (upd_we && (upd_idx == lk_idx[i])) ? upd_ent : tbl_q[lk_idx[i]];
      if (state_q == BP_RUN && lk_ent[i].valid && (lk_ent[i].tag == lk_tag[i])) begin
        lk_hit_d[i]                    = 1'b1;
        lk_taken_d[i]                  = (lk_ent[i].ctr >= CTR_WT);
        lk_target_d[i*PC_W +: PC_W]    = PC_W'(lk_ent[i].target);
      end
    end
  end

  // Lookup result registers, frozen while F is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lk_hit_q    <= '0;
      lk_taken_q  <= '0;
      lk_target_q <= '0;
    end else if (!bp_io.hold) begin
      lk_hit_q    <= lk_hit_d;
      lk_taken_q  <= lk_taken_d;
      lk_target_q <= lk_target_d;
    end
  end

  assign bp_io.lk_hit    = lk_hit_q;
  assign bp_io.lk_taken  = lk_taken_q;
  assign bp_io.lk_target = lk_target_q;
  assign bp_io.ready     = ready_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: 2 lanes, 256 entries, 13-bit PCs.
module tb_branch_predictor;

  localparam int unsigned PcW = 13;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(PcW), .LANES(2)) bus ();

  branch_predictor #(
    .PC_W    (PcW),
    .ENTRIES (256),
    .LANES   (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bp_io (bus)
  );

  typedef struct {
    string          name;
    logic [1:0]     hit;
    logic [1:0]     tkn;
    logic [PcW-1:0] t0;
    logic [PcW-1:0] t1;
    logic           rdy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic req     = 1'b0;
  logic rsp_vld = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // A request sampled at an edge is presented on lk_*/ready right after that edge.
  always @(posedge clk) rsp_vld <= req;

  // Monitor: pop one expectation per presented response.
  always @(negedge clk) begin
    if (rsp_vld) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: response with no expectation at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.lk_hit !== mon_e.hit || bus.lk_taken !== mon_e.tkn ||
            bus.lk_target[PcW-1:0] !== mon_e.t0 || bus.lk_target[2*PcW-1:PcW] !== mon_e.t1 ||
            bus.ready !== mon_e.rdy) begin
          errors++;
          $display("FAIL %s @%0t: got hit=%b taken=%b tgt0=%h tgt1=%h ready=%b, want hit=%b taken=%b tgt0=%h tgt1=%h ready=%b",
                   mon_e.name, $time, bus.lk_hit, bus.lk_taken, bus.lk_target[PcW-1:0],
                   bus.lk_target[2*PcW-1:PcW], bus.ready, mon_e.hit, mon_e.tkn, mon_e.t0,
                   mon_e.t1, mon_e.rdy);
        end
      end
    end
  end

  // Drive one cycle of stimulus and queue its expected response.
  task automatic issue(input string name, input logic [PcW-1:0] p0, input logic [PcW-1:0] p1,
                       input logic uv, input logic [PcW-1:0] upc, input logic ut,
                       input logic [PcW-1:0] utg, input logic hd,
                       input logic [1:0] eh, input logic [1:0] et,
                       input logic [PcW-1:0] e0, input logic [PcW-1:0] e1, input logic er);
    exp_t e;
    bus.lk_pc      = {p1, p0};
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utg;
    bus.hold       = hd;
    req            = 1'b1;
    e.name = name;
    e.hit  = eh;
    e.tkn  = et;
    e.t0   = e0;
    e.t1   = e1;
    e.rdy  = er;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PcW-1:0] apc [10];
    logic [PcW-1:0] atg [10];
    rst            = 1'b1;
    bus.hold       = 1'b0;
    bus.lk_pc      = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    @(posedge clk);
    #2;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++)
      issue("reset", 13'h040, 13'h044, 1'b1, 13'h040, 1'b1, 13'h100, 1'b0,
            2'b00, 2'b00, '0, '0, 1'b0);
    rst = 1'b0;

    // Clear sweep: ready on the 256th edge, no hits, updates dropped (incl. last sweep cycle).
    for (int k = 1; k <= 257; k++)
      issue("clear", 13'h040, 13'h044, (k == 250 || k == 256), 13'h040, 1'b1, 13'h100, 1'b0,
            2'b00, 2'b00, '0, '0, (k >= 256));

    // Allocate and saturate at 0x040 (lane0), lane1 0x044 misses.
    issue("alloc",   13'h040, 13'h044, 1, 13'h040, 1, 13'h100, 0, 2'b01, 2'b01, 13'h100, 0, 1);
    issue("alloc_rd",13'h040, 13'h044, 0, 13'h040, 0, 13'h000, 0, 2'b01, 2'b01, 13'h100, 0, 1);
    issue("ctr3",    13'h040, 13'h044, 1, 13'h040, 1, 13'h100, 0, 2'b01, 2'b01, 13'h100, 0, 1);
    issue("ctr_sat3",13'h040, 13'h044, 1, 13'h040, 1, 13'h100, 0, 2'b01, 2'b01, 13'h100, 0, 1);
    issue("ctr2",    13'h040, 13'h044, 1, 13'h040, 0, 13'h1f0, 0, 2'b01, 2'b01, 13'h100, 0, 1);
    issue("ctr1",    13'h040, 13'h044, 1, 13'h040, 0, 13'h1f0, 0, 2'b01, 2'b00, 13'h100, 0, 1);
    issue("ctr0",    13'h040, 13'h044, 1, 13'h040, 0, 13'h1f0, 0, 2'b01, 2'b00, 13'h100, 0, 1);
    issue("ctr_sat0",13'h040, 13'h044, 1, 13'h040, 0, 13'h1f0, 0, 2'b01, 2'b00, 13'h100, 0, 1);
    issue("ctr0to1", 13'h040, 13'h044, 1, 13'h040, 1, 13'h120, 0, 2'b01, 2'b00, 13'h120, 0, 1);

    // Tag conflict: 0x440 evicts 0x040 at index 0x10.
    issue("conflict",   13'h040, 13'h440, 1, 13'h440, 1, 13'h300, 0, 2'b10, 2'b10, 0, 13'h300, 1);
    issue("conflict_rd",13'h040, 13'h440, 0, 13'h440, 0, 13'h000, 0, 2'b10, 2'b10, 0, 13'h300, 1);

    // Same-cycle bypass on lane0 only, then swapped lanes from the table.
    issue("bypass",   13'h080, 13'h084, 1, 13'h080, 1, 13'h200, 0, 2'b01, 2'b01, 13'h200, 0, 1);
    issue("bypass_rd",13'h084, 13'h080, 0, 13'h080, 0, 13'h000, 0, 2'b10, 2'b10, 0, 13'h200, 1);

    // Not-taken miss allocates nothing.
    issue("nt_miss",   13'h0c0, 13'h044, 1, 13'h0c0, 0, 13'h0f0, 0, 2'b00, 2'b00, 0, 0, 1);
    issue("nt_miss_rd",13'h0c0, 13'h044, 0, 13'h0c0, 0, 13'h000, 0, 2'b00, 2'b00, 0, 0, 1);

    // Hold: outputs frozen for 4 cycles while the table still takes an update.
    issue("pre_hold", 13'h440, 13'h080, 0, 13'h000, 0, 13'h000, 0, 2'b11, 2'b11, 13'h300, 13'h200, 1);
    issue("hold",     13'h080, 13'h100, 1, 13'h100, 1, 13'h3a0, 1, 2'b11, 2'b11, 13'h300, 13'h200, 1);
    for (int i = 0; i < 3; i++)
      issue("hold",   13'h080, 13'h100, 0, 13'h000, 0, 13'h000, 1, 2'b11, 2'b11, 13'h300, 13'h200, 1);
    issue("unhold",   13'h080, 13'h100, 0, 13'h000, 0, 13'h000, 0, 2'b11, 2'b11, 13'h200, 13'h3a0, 1);

    // Ten allocations, then reset mid-run.
    for (int i = 0; i < 10; i++) begin
      apc[i] = 13'h800 + PcW'(4 * i);
      atg[i] = PcW'(16 * (i + 1));
      issue("alloc10", apc[i], 13'h044, 1, apc[i], 1, atg[i], 0, 2'b01, 2'b01, atg[i], 0, 1);
    end
    issue("alloc10_rd", apc[0], apc[9], 0, 13'h000, 0, 13'h000, 0, 2'b11, 2'b11, atg[0], atg[9], 1);
    rst = 1'b1;
    issue("reset_run", apc[0], apc[9], 1, 13'h0c0, 1, 13'h0f0, 0, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b0;
    for (int k = 1; k <= 256; k++)
      issue("reclear", apc[0], apc[9], 0, 13'h000, 0, 13'h000, 0, 2'b00, 2'b00, 0, 0, (k >= 256));
    for (int i = 0; i < 10; i += 2)
      issue("after_reset", apc[i], apc[i+1], 0, 13'h000, 0, 13'h000, 0, 2'b00, 2'b00, 0, 0, 1);
    issue("after_reset", 13'h440, 13'h080, 0, 13'h000, 0, 13'h000, 0, 2'b00, 2'b00, 0, 0, 1);
    issue("after_reset", 13'h100, 13'h0c0, 0, 13'h000, 0, 13'h000, 0, 2'b00, 2'b00, 0, 0, 1);

    req = 1'b0;
    bus.upd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters. It serves LANES fetch slots per cycle and takes one resolution update per cycle from the E-stage PC calculator. It sits beside the instruction ROM in F and replaces the fixed dual-issue, fixed-size predictor table. Unlike that table, it has a configurable lane count and depth, self-clears after reset, and bypasses same-cycle updates into lookups.

## Interface
- PC_W, 13, byte-address width of PCs and targets
- ENTRIES, 256, table depth; power of two, 4..4096; IDX_W = log2(ENTRIES)
- LANES, 2, number of parallel lookup slots, 1..4
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset; synchronous, active-high
- hold  in  1  F-stage stall; freezes lookup output registers
- lk_pc  in  LANES*PC_W  lookup PCs, lane i at bits [i*PC_W +: PC_W]
- lk_hit  out  LANES  valid, tag-matching entry found
- lk_taken  out  LANES  hit and counter >= 2
- lk_target  out  LANES*PC_W  stored target; 0 when not hit
- upd_valid  in  1  E-stage branch/jump resolved this cycle
- upd_pc  in  PC_W  PC of resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual target (ignored when not taken)
- ready  out  1  clear sweep finished; table is usable

## Operation
- PCs are 4-byte aligned. Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2]; if PC_W <= IDX_W+2, the tag is 0 bits and only valid is checked.
- Each entry holds valid, tag, ctr[1:0], and target[PC_W-1:0].
- The FSM has two states, CLEAR and RUN.
  - RST forces CLEAR with clr_idx = 0.
  - In CLEAR, one entry per cycle gets valid = 0. clr_idx increments each cycle. After index ENTRIES-1 the FSM goes to RUN.
  - In CLEAR, ready = 0, all lookups report miss, and updates are dropped.
- Update rules in RUN when upd_valid = 1:
  - Hit and taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit and not taken: ctr = max(ctr-1, 0); target is unchanged.
  - Miss and taken: allocate the entry, overwriting whatever occupies the index. Set valid = 1, tag = new tag, ctr = 2, target = upd_target.
  - Miss and not taken: no change.
- Lookup: each lane reads independently. Several lanes may hit the same index.
- Bypass: if upd_valid and a lane's index match in the same cycle, that lane sees the post-update entry.
- hold = 1 keeps all lk_* registers unchanged. The table still accepts updates while hold is high.
- RST asserted mid-sweep or mid-run restarts CLEAR from index 0. Any update pending in that cycle is dropped.

## Timing
- Lookup latency is 1 cycle: lk_pc sampled at edge N appears on lk_* after edge N.
- An update sampled at edge N is visible to lookups sampled at edge N through the bypass, and to all later lookups.
- Clear takes exactly ENTRIES cycles: ready rises on the edge that completes index ENTRIES-1, i.e. ENTRIES cycles after the last cycle with RST = 1.
- Reset values: lk_hit = 0, lk_taken = 0, lk_target = 0, ready = 0.
- Counter saturates at 0 and 3; it never wraps.
- clr_idx is IDX_W+1 bits so that it cannot wrap before reaching RUN.

## Structure
- The shared package bp_pkg holds:
  - the FSM enum: BP_CLEAR, BP_RUN
  - counter constants: CTR_SNT = 0, CTR_WNT = 1, CTR_WT = 2, CTR_ST = 3
  - the entry struct layout
- bp_ctr2 is one sub-module: pure saturating 2-bit update, inputs ctr and taken, output next ctr.
- The table is a flat register array. Read ports are replicated per lane; there is one write port, shared by the clear sweep and updates.

## Test plan
- Reset and clear: hold RST for 3 cycles, then release with ENTRIES = 256. ready stays 0 for 256 cycles and rises on cycle 256. lk_hit stays 0 throughout, even with upd_valid pulsed during the sweep.
- Allocate and saturate: upd pc = 0x040, taken, target 0x100. Next cycle lookup 0x040 gives hit = 1, taken = 1, target 0x100. Two more taken updates leave ctr = 3. Then three not-taken updates leave ctr = 0 and taken = 0, hit still 1.
- Tag conflict: allocate pc 0x040, then allocate pc 0x440, which has the same index with ENTRIES = 256. Lookup 0x040 now misses; lookup 0x440 hits with the new target.
- Bypass, two lanes: in the same cycle, upd pc = 0x080 taken target 0x200 and lookup lane0 = 0x080, lane1 = 0x084. Lane0 shows hit, target 0x200. Lane1 shows miss.
- Hold: hold = 1 with lk_pc changing from 0x040 to 0x080 for 4 cycles. lk_* stay frozen at the 0x040 result. Release hold and the 0x080 result appears one cycle later.
- Reset mid-run: assert RST for 1 cycle after 10 allocations. ready drops, the FSM re-clears for 256 cycles, and every previously allocated PC misses afterwards.
